// File: rtl/pipe_stage_skid.sv
// Pipeline register with a two-entry skid buffer, global stall, flush-to-bubble
// and saturating stall/flush event counters.
module pipe_stage_skid #(
    parameter int unsigned        DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              push_c, pop_c;

    // Ready is registered; stall only masks it, it never reaches OUT_READY.
    assign IN_READY  = in_ready_q & ~STALL;
    assign OUT_VALID = (state_q != EMPTY);
    assign OUT_DATA  = main_q;
    assign OCCUPANCY = 2'(state_q);

    assign push_c = IN_VALID & in_ready_q & ~STALL & ~FLUSH;
    assign pop_c  = OUT_VALID & OUT_READY & ~STALL;

    // Next-state and register update; main is returned to NOP whenever it empties.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_c) begin
                        state_d = FULL;
                        main_d  = IN_DATA;
                    end
                end
                FULL: begin
                    if (push_c && !pop_c) begin
                        state_d = SKID;
                        skid_d  = IN_DATA;
                    end else if (push_c && pop_c) begin
                        main_d  = IN_DATA;
                    end else if (pop_c) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                SKID: begin
                    if (pop_c) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= EMPTY;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (STALL && (STALL_CNT != CNT_MAX)) STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (FLUSH && (FLUSH_CNT != CNT_MAX)) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, stall, flush,
// async reset and counter saturation with a 4-bit counter build.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .OCCUPANCY(occupancy), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic [1:0] occ, input logic rdy);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".occ"},   64'(occupancy), 64'(occ));
        chk({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk_out("reset", 1'b0, NOP, 2'd0, 1'b1);
        chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset.flush_cnt", 64'(flush_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Streaming at full throughput
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h11; step(); chk_out("stream1", 1'b1, 32'h11, 2'd1, 1'b1);
        in_data = 32'h22; step(); chk_out("stream2", 1'b1, 32'h22, 2'd1, 1'b1);
        in_data = 32'h33; step(); chk_out("stream3", 1'b1, 32'h33, 2'd1, 1'b1);
        in_valid = 1'b0;  step(); chk_out("stream_drain", 1'b0, NOP, 2'd0, 1'b1);

        // Backpressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hA1; step(); chk_out("bp_push1", 1'b1, 32'hA1, 2'd1, 1'b1);
        in_data = 32'hA2; step(); chk_out("bp_push2", 1'b1, 32'hA1, 2'd2, 1'b0);
        in_data = 32'hA9;  step(); chk_out("bp_blocked", 1'b1, 32'hA1, 2'd2, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); chk_out("bp_pop1", 1'b1, 32'hA2, 2'd1, 1'b1);
        step(); chk_out("bp_pop2", 1'b0, NOP, 2'd0, 1'b1);

        // Stall holds a full stage
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        step(); chk_out("stall_fill", 1'b1, 32'h55, 2'd1, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk_out("stall_hold", 1'b1, 32'h55, 2'd1, 1'b0);
        end
        chk("stall.cnt4", 64'(stall_cnt), 64'd4);
        stall = 1'b0; #1;
        chk("stall.release_ready", 64'(in_ready), 64'd1);
        step(); chk_out("stall_pop", 1'b0, NOP, 2'd0, 1'b1);
        chk("stall.cnt_after", 64'(stall_cnt), 64'd4);

        // Flush from SKID discards the simultaneous push
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hB1; step();
        in_data = 32'hB2; step(); chk_out("flush_pre", 1'b1, 32'hB1, 2'd2, 1'b0);
        in_data = 32'hB3; flush = 1'b1;
        step(); chk_out("flush", 1'b0, NOP, 2'd0, 1'b1);
        chk("flush.cnt1", 64'(flush_cnt), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        step(); chk_out("flush_nocapture", 1'b0, NOP, 2'd0, 1'b1);

        // Flush wins over stall; both counters advance
        in_valid = 1'b1; in_data = 32'hC1; step();
        chk_out("fs_fill", 1'b1, 32'hC1, 2'd1, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; stall = 1'b1;
        step(); flush = 1'b0; stall = 1'b0; #1;
        chk_out("fs_flush", 1'b0, NOP, 2'd0, 1'b1);
        chk("fs.stall_cnt", 64'(stall_cnt), 64'd5);
        chk("fs.flush_cnt", 64'(flush_cnt), 64'd2);

        // Asynchronous reset while in SKID
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hD1; step();
        in_data = 32'hD2; step(); chk_out("ar_pre", 1'b1, 32'hD1, 2'd2, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("ar_async", 1'b0, NOP, 2'd0, 1'b1);
        chk("ar.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("ar.flush_cnt", 64'(flush_cnt), 64'd0);
        rst = 1'b0;
        step(); chk_out("ar_after", 1'b0, NOP, 2'd0, 1'b1);

        // Counter saturation at 2^CNT_W-1
        stall = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("sat.cnt14", 64'(stall_cnt), 64'd14);
        step(); chk("sat.cnt15", 64'(stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) step();
        chk("sat.hold15", 64'(stall_cnt), 64'd15);
        stall = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline register placed between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W-bit payload under a valid/ready handshake, with a 2-entry skid buffer so IN_READY is purely registered.
- Supports a global hold driven by cache busywait (STALL) and a branch/jump FLUSH that inserts NOP bubbles.
- Counts stall and flush events for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (instruction plus PC, or decoded control bundle).
- NOP_VALUE, 0 (DATA_W bits), payload driven when no valid entry is held; for IF/ID use the 32-bit value 0x00000013 in the instruction field.
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  global hold (instruction or data cache busywait).
- FLUSH  in  1  discard all held entries (taken branch or jump).
- IN_VALID  in  1  upstream payload valid.
- IN_READY  out  1  stage can accept a payload; registered.
- IN_DATA  in  DATA_W  upstream payload.
- OUT_VALID  out  1  OUT_DATA holds a valid entry.
- OUT_READY  in  1  downstream accepts the payload.
- OUT_DATA  out  DATA_W  head entry, or NOP_VALUE when empty.
- OCCUPANCY  out  2  number of entries held (0 to 2).
- STALL_CNT  out  CNT_W  cycles with STALL=1.
- FLUSH_CNT  out  CNT_W  cycles with FLUSH=1.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock needed):
  - State is EMPTY.
  - OUT_VALID=0, OUT_DATA=NOP_VALUE, IN_READY=1, OCCUPANCY=0.
  - Both counters are 0; the skid register is cleared to NOP_VALUE.
- Handshake definitions:
  - Push = IN_VALID & IN_READY & ~STALL & ~FLUSH.
  - Pop = OUT_VALID & OUT_READY & ~STALL.
- States and transitions:
  - EMPTY, main register invalid: on Push go to FULL, with main <= IN_DATA.
  - FULL, main register valid:
    - Push without Pop: go to SKID, with skid <= IN_DATA.
    - Push with Pop: stay in FULL, with main <= IN_DATA.
    - Pop alone: go to EMPTY.
  - SKID, both registers valid:
    - Pop: go to FULL, with main <= skid.
    - No Push is possible in this state because IN_READY=0.
- IN_READY = registered (next_state != SKID), and is additionally forced to 0 while STALL=1.
  - The registered part contains no combinational path from OUT_READY.
  - If the upstream asserts IN_VALID while IN_READY=0, the payload is not captured and the upstream must hold it.
- Output ordering and bubbles:
  - Payloads leave in FIFO order.
  - OUT_DATA is driven from the main register.
  - OUT_DATA is NOP_VALUE whenever OUT_VALID=0, so downstream sees a bubble.
- Latency:
  - 1 cycle from Push to OUT_VALID when EMPTY.
  - Throughput is 1 payload per cycle when OUT_READY=1 and STALL=0.
- STALL:
  - Freezes the state and both registers; no Push or Pop occurs.
  - OUT_VALID and OUT_DATA hold their values.
  - STALL_CNT increments each cycle.
- FLUSH:
  - Has highest priority after reset.
  - On the next edge the state goes to EMPTY, both registers are cleared to NOP_VALUE, and IN_READY goes to 1.
  - Any simultaneous Push or Pop is discarded.
  - FLUSH_CNT increments each cycle FLUSH=1.
- FLUSH and STALL together: FLUSH wins, and both counters increment.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- OCCUPANCY is 0, 1 or 2 for EMPTY, FULL or SKID respectively.
- Reset asserted mid-operation drops all entries immediately; there is no partial-update state.

Test Plan:
- Reset then stream, OUT_READY=1: push 0x11,0x22,0x33 on consecutive cycles -> OUT_DATA shows 0x11,0x22,0x33 on cycles 1,2,3 with OUT_VALID=1; OCCUPANCY stays 1; IN_READY stays 1.
- Backpressure: OUT_READY=0, push 0xA1 then 0xA2 -> OCCUPANCY=2 and IN_READY=0 on the cycle after the second push. Then raise OUT_READY -> 0xA1 then 0xA2 appear in order, and IN_READY returns to 1 after the first pop.
- STALL hold: in FULL holding 0x55 with OUT_READY=1, assert STALL for 4 cycles -> OUT_DATA stays 0x55, no pop occurs, IN_READY=0, STALL_CNT=4. On release, 0x55 pops on the next cycle.
- FLUSH priority: in SKID holding 0xB1,0xB2, assert FLUSH with IN_VALID=1 carrying 0xB3 -> on the next cycle OUT_VALID=0, OUT_DATA=NOP_VALUE, OCCUPANCY=0, FLUSH_CNT=1, and 0xB3 is not captured.
- Async reset mid-stream: assert RESET between clock edges while in SKID -> OUT_VALID=0 and IN_READY=1 immediately, before the next CLK edge; both counters are 0.
- Counter saturation, CNT_W=4: hold STALL for 20 cycles -> STALL_CNT reaches 15 and stays at 15.
